// File: rtl/demux1x2_32_buffered.sv
// 1-to-2 word demux with a private FIFO per destination.
// Select steers each accepted word; each side drains on its own handshake.
module demux1x2_32_buffered_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = valid ? mem_q[rd_q] : '0;
endmodule

module demux1x2_32_buffered #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Select,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] DataOut1,
  output logic             Valid1,
  input  logic             Ready1,
  output logic [CW-1:0]    Count1,
  output logic [WIDTH-1:0] DataOut2,
  output logic             Valid2,
  input  logic             Ready2,
  output logic [CW-1:0]    Count2
);
  logic full1, full2;
  logic push1, push2;
  logic pop1, pop2;
  logic acc;

  // Only the selected side's fullness gates acceptance.
  assign InReady = !Reset && !(Select ? full2 : full1);
  assign acc     = InValid && InReady;
  assign push1   = acc && !Select;
  assign push2   = acc && Select;
  assign pop1    = !Reset && Valid1 && Ready1;
  assign pop2    = !Reset && Valid2 && Ready2;

  demux1x2_32_buffered_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo1 (
    .clk  (Clock),
    .rst  (Reset),
    .push (push1),
    .pop  (pop1),
    .din  (DataIn),
    .dout (DataOut1),
    .valid(Valid1),
    .full (full1),
    .count(Count1)
  );

  demux1x2_32_buffered_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo2 (
    .clk  (Clock),
    .rst  (Reset),
    .push (push2),
    .pop  (pop2),
    .din  (DataIn),
    .dout (DataOut2),
    .valid(Valid2),
    .full (full2),
    .count(Count2)
  );
endmodule

// File: tb/tb_demux1x2_32_buffered.sv
// Directed and scoreboarded checks for demux1x2_32_buffered.
// Inputs change 1ns after a rising edge; outputs are read 1ns later.
module tb_demux1x2_32_buffered;
  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] DataIn;
  logic        Select;
  logic        InValid;
  logic        InReady;
  logic [31:0] DataOut1;
  logic        Valid1;
  logic        Ready1;
  logic [1:0]  Count1;
  logic [31:0] DataOut2;
  logic        Valid2;
  logic        Ready2;
  logic [1:0]  Count2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];

  demux1x2_32_buffered dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .DataIn  (DataIn),
    .Select  (Select),
    .InValid (InValid),
    .InReady (InReady),
    .DataOut1(DataOut1),
    .Valid1  (Valid1),
    .Ready1  (Ready1),
    .Count1  (Count1),
    .DataOut2(DataOut2),
    .Valid2  (Valid2),
    .Ready2  (Ready2),
    .Count2  (Count2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset   = 1'b1;
    DataIn  = '0;
    Select  = 1'b0;
    InValid = 1'b0;
    Ready1  = 1'b1;
    Ready2  = 1'b1;
    step();
    step();
    chk("rst_inready", 32'(InReady), 32'd0);
    Reset = 1'b0;
    #1;
    chk("rst_valid1", 32'(Valid1), 32'd0);
    chk("rst_valid2", 32'(Valid2), 32'd0);
    chk("rst_count1", 32'(Count1), 32'd0);
    chk("rst_count2", 32'(Count2), 32'd0);
    chk("rst_dout1", DataOut1, 32'd0);
    chk("rst_dout2", DataOut2, 32'd0);
    chk("rst_inready_lo", 32'(InReady), 32'd1);

    // single push to output 1
    Ready1  = 1'b0;
    DataIn  = 32'hDEADBEEF;
    Select  = 1'b0;
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    #1;
    chk("p1_valid1", 32'(Valid1), 32'd1);
    chk("p1_dout1", DataOut1, 32'hDEADBEEF);
    chk("p1_count1", 32'(Count1), 32'd1);
    chk("p1_valid2", 32'(Valid2), 32'd0);

    // fill output 2 while it stalls
    Ready2  = 1'b0;
    Select  = 1'b1;
    InValid = 1'b1;
    DataIn  = 32'hA1;
    step();
    DataIn  = 32'hA2;
    step();
    InValid = 1'b0;
    #1;
    chk("f2_count2", 32'(Count2), 32'd2);
    chk("f2_inready_s1", 32'(InReady), 32'd0);
    Select = 1'b0;
    #1;
    chk("f2_inready_s0", 32'(InReady), 32'd1);
    Ready2 = 1'b1;
    #1;
    chk("f2_head_a1", DataOut2, 32'hA1);
    step();
    chk("f2_head_a2", DataOut2, 32'hA2);
    chk("f2_count2_1", 32'(Count2), 32'd1);
    step();
    chk("f2_count2_0", 32'(Count2), 32'd0);
    chk("f2_valid2_0", 32'(Valid2), 32'd0);
    chk("f2_dout2_0", DataOut2, 32'd0);

    // push and pop on FIFO 1 together
    Select  = 1'b0;
    DataIn  = 32'h0000_000B;
    InValid = 1'b1;
    Ready1  = 1'b1;
    step();
    InValid = 1'b0;
    Ready1  = 1'b0;
    #1;
    chk("pp_count1", 32'(Count1), 32'd1);
    chk("pp_dout1", DataOut1, 32'h0000_000B);

    // fill FIFO 1, then no push-through when full
    DataIn  = 32'h0000_000C;
    InValid = 1'b1;
    step();
    #1;
    chk("fl_count1", 32'(Count1), 32'd2);
    chk("fl_inready", 32'(InReady), 32'd0);
    DataIn = 32'h0000_000D;
    Ready1 = 1'b1;
    #1;
    chk("fl_inready_rdy", 32'(InReady), 32'd0);
    step();
    Ready1 = 1'b0;
    #1;
    chk("fl_count1_pop", 32'(Count1), 32'd1);
    chk("fl_dout1_c", DataOut1, 32'h0000_000C);
    chk("fl_inready_free", 32'(InReady), 32'd1);
    step();
    chk("fl_count1_2", 32'(Count1), 32'd2);

    // reset mid-stream discards everything
    Reset   = 1'b1;
    DataIn  = 32'h0000_000E;
    Ready1  = 1'b1;
    step();
    Reset   = 1'b0;
    InValid = 1'b0;
    Ready1  = 1'b0;
    #1;
    chk("mr_count1", 32'(Count1), 32'd0);
    chk("mr_valid1", 32'(Valid1), 32'd0);
    chk("mr_dout1", DataOut1, 32'd0);
    step();
    chk("mr_count1_b", 32'(Count1), 32'd0);

    // random traffic against a queue model
    for (int i = 0; i < 1000; i++) begin
      bit exp_rdy;
      bit pu;
      DataIn  = $urandom;
      Select  = 1'($urandom_range(1));
      InValid = 1'($urandom_range(1));
      Ready1  = 1'($urandom_range(1));
      Ready2  = 1'($urandom_range(1));
      #1;
      exp_rdy = Select ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
      chk("rn_count1", 32'(Count1), 32'(q1.size()));
      chk("rn_count2", 32'(Count2), 32'(q2.size()));
      chk("rn_valid1", 32'(Valid1), 32'(q1.size() != 0));
      chk("rn_valid2", 32'(Valid2), 32'(q2.size() != 0));
      chk("rn_dout1", DataOut1, q1.size() != 0 ? q1[0] : 32'd0);
      chk("rn_dout2", DataOut2, q2.size() != 0 ? q2[0] : 32'd0);
      chk("rn_inready", 32'(InReady), 32'(exp_rdy));
      pu = InValid && exp_rdy;
      if (Ready1 && q1.size() != 0) void'(q1.pop_front());
      if (Ready2 && q2.size() != 0) void'(q2.pop_front());
      if (pu && !Select) q1.push_back(DataIn);
      if (pu && Select) q2.push_back(DataIn);
      step();
    end

    // drain and confirm nothing left over
    InValid = 1'b0;
    Ready1  = 1'b1;
    Ready2  = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      #1;
      chk("dr_dout1", DataOut1, q1.size() != 0 ? q1[0] : 32'd0);
      chk("dr_dout2", DataOut2, q2.size() != 0 ? q2[0] : 32'd0);
      if (q1.size() != 0) void'(q1.pop_front());
      if (q2.size() != 0) void'(q2.pop_front());
      step();
    end
    chk("dr_count1", 32'(Count1), 32'd0);
    chk("dr_count2", 32'(Count2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
